// File: rtl/elem_mem_pkg.sv
// Shared types and constants for the element-memory arbiter and its
// priority picker.
package elem_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int CLI_CFG  = 0;
  localparam int CLI_UI   = 1;
  localparam int CLI_EJEC = 2;

  localparam int DEF_DEPTH = 60;
  localparam int DEF_DW    = 800;

endpackage

// File: rtl/elem_mem_arbiter_rr_pick.sv
// Combinational priority encoder: lowest eligible index in fixed mode, or the
// first eligible index after the pointer (wrapping) in round-robin mode.
module rr_pick
  import elem_mem_pkg::*;
#(
  parameter int NCLI = 3,
  parameter int IW   = $clog2(NCLI)
) (
  input  logic [NCLI-1:0] elig_i,
  input  logic [IW-1:0]   ptr_i,
  input  logic            mode_rr_i,
  output logic [IW-1:0]   win_o,
  output logic            any_o
);

  // Candidates are scanned farthest-first so the nearest eligible one is written last.
  always_comb begin
    logic [NCLI-1:0] sh_s;
    int              pos_s;
    win_o = {IW{1'b0}};
    any_o = |elig_i;
    sh_s  = {NCLI{1'b0}};
    pos_s = 0;
    if (mode_rr_i) begin
      for (int off = NCLI; off >= 1; off--) begin
        pos_s = (int'(ptr_i) + off) % NCLI;
        sh_s  = elig_i >> pos_s;
        win_o = sh_s[0] ? IW'(pos_s) : win_o;
      end
    end else begin
      for (int i = NCLI - 1; i >= 0; i--) begin
        sh_s  = elig_i >> i;
        win_o = sh_s[0] ? IW'(i) : win_o;
      end
    end
  end

endmodule

// File: rtl/elem_mem_arbiter.sv
// Arbitrates NCLI clients onto the single-port element RAM with multi-beat
// wrapping bursts, fixed/round-robin priority, a config lock and tagged read return.
module elem_mem_arbiter
  import elem_mem_pkg::*;
#(
  parameter int NCLI  = 3,
  parameter int AW    = 7,
  parameter int DW    = DEF_DW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int BW    = 6,
  parameter int RDLAT = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_lock_i,
  input  logic                 mode_rr_i,
  input  logic [NCLI-1:0]      req_i,
  input  logic [NCLI-1:0]      wr_i,
  input  logic [NCLI*AW-1:0]   addr_i,
  input  logic [NCLI*BW-1:0]   len_i,
  input  logic [NCLI*DW-1:0]   wdata_i,
  output logic [NCLI-1:0]      gnt_o,
  output logic [NCLI-1:0]      act_o,
  output logic [NCLI-1:0]      rvalid_o,
  output logic [DW-1:0]        rdata_o,
  output logic [NCLI-1:0]      done_o,
  output logic [NCLI-1:0]      err_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [AW-1:0]        mem_addr_o,
  output logic [DW-1:0]        mem_din_o,
  input  logic [DW-1:0]        mem_dout_i
);

  localparam int IW  = $clog2(NCLI);
  localparam int PW  = RDLAT * IW;
  localparam int AW1 = AW + 1;
  localparam logic [AW-1:0]    LAST_A    = AW'(DEPTH - 1);
  localparam logic [AW:0]      DEPTH_W   = AW1'(DEPTH);
  // Every pipe stage except the output one; reads still there are outstanding.
  localparam logic [RDLAT-1:0] PEND_MASK = {RDLAT{1'b1}} >> 1;

  function automatic logic [NCLI-1:0] to_oh(input logic [IW-1:0] i);
    logic [NCLI-1:0] one;
    one = {{(NCLI-1){1'b0}}, 1'b1};
    return one << i;
  endfunction

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d, ptr_q, ptr_d;
  logic [AW-1:0]   cur_q, cur_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [NCLI-1:0] done_q, done_d, err_q, err_d;
  logic [RDLAT-1:0] rv_q;
  logic [PW-1:0]   rid_q;

  logic [NCLI-1:0] elig_s, wr_sh_s;
  logic [IW-1:0]   win_s;
  logic            any_s, pend_s, issue_rd_s;
  logic [AW-1:0]   win_addr_s;
  logic [BW-1:0]   win_len_s;

  assign elig_s     = cfg_lock_i ? {{(NCLI-1){1'b0}}, req_i[CLI_CFG]} : req_i;
  assign win_addr_s = AW'(addr_i >> (int'(win_s) * AW));
  assign win_len_s  = BW'(len_i >> (int'(win_s) * BW));
  assign wr_sh_s    = wr_i >> win_s;
  assign pend_s     = |(rv_q & PEND_MASK);
  assign issue_rd_s = (state_q == BURST) && !wr_q;

  rr_pick #(
    .NCLI (NCLI),
    .IW   (IW)
  ) u_pick (
    .elig_i    (elig_s),
    .ptr_i     (ptr_q),
    .mode_rr_i (mode_rr_i),
    .win_o     (win_s),
    .any_o     (any_s)
  );

  // Next-state logic; a pending err pulse suppresses arbitration for one cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    done_d  = {NCLI{1'b0}};
    err_d   = {NCLI{1'b0}};
    case (state_q)
      IDLE: begin
        if (any_s && (err_q == {NCLI{1'b0}})) begin
          if ({1'b0, win_addr_s} >= DEPTH_W) begin
            err_d = to_oh(win_s);
          end else begin
            idx_d   = win_s;
            ptr_d   = win_s;
            cur_d   = win_addr_s;
            cnt_d   = win_len_s;
            wr_d    = wr_sh_s[0];
            state_d = BURST;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        cur_d = (cur_q == LAST_A) ? {AW{1'b0}} : cur_q + AW'(1);
        if (cnt_q == {BW{1'b0}}) begin
          if (wr_q) begin
            done_d  = to_oh(idx_q);
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          cnt_d = cnt_q - BW'(1);
        end
      end
      DRAIN: begin
        if (!pend_s) begin
          done_d  = to_oh(idx_q);
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, burst context and read-return pipe registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= {IW{1'b0}};
      ptr_q   <= IW'(NCLI - 1);
      cur_q   <= {AW{1'b0}};
      cnt_q   <= {BW{1'b0}};
      wr_q    <= 1'b0;
      done_q  <= {NCLI{1'b0}};
      err_q   <= {NCLI{1'b0}};
      rv_q    <= {RDLAT{1'b0}};
      rid_q   <= {PW{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rv_q    <= (rv_q << 1) | RDLAT'(issue_rd_s);
      rid_q   <= (rid_q << IW) | PW'(idx_q);
    end
  end

  assign gnt_o      = (state_q != IDLE)  ? to_oh(idx_q) : {NCLI{1'b0}};
  assign act_o      = (state_q == BURST) ? to_oh(idx_q) : {NCLI{1'b0}};
  assign mem_en_o   = (state_q == BURST);
  assign mem_we_o   = (state_q == BURST) && wr_q;
  assign mem_addr_o = (state_q == BURST) ? cur_q : {AW{1'b0}};
  assign mem_din_o  = (state_q == BURST) ? DW'(wdata_i >> (int'(idx_q) * DW)) : {DW{1'b0}};
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rvalid_o   = rv_q[RDLAT-1] ? to_oh(rid_q[(RDLAT-1)*IW +: IW]) : {NCLI{1'b0}};
  assign rdata_o    = rv_q[RDLAT-1] ? mem_dout_i : {DW{1'b0}};

endmodule

// File: tb/tb_elem_mem_arbiter.sv
// Directed bench: two arbiters (read latency 1 and 2) share stimulus, each
// backed by a small behavioural RAM; expectations are hand-derived per cycle.
module tb_elem_mem_arbiter;

  localparam int NCLI  = 3;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int DEPTH = 60;
  localparam int BW    = 6;

  logic clk;
  logic rst_n, cfg_lock, mode_rr;
  logic [NCLI-1:0]    req, wr;
  logic [NCLI*AW-1:0] addr;
  logic [NCLI*BW-1:0] len;
  logic [NCLI*DW-1:0] wdata;

  logic [NCLI-1:0] gnt1, act1, rv1, done1, err1, gnt2, act2, rv2, done2, err2;
  logic [DW-1:0]   rd1, rd2, md1, md2, dout1, dout2;
  logic            en1, we1, en2, we2;
  logic [AW-1:0]   ma1, ma2;

  logic [DW-1:0] ram1 [0:127];
  logic [DW-1:0] ram2 [0:127];
  logic [DW-1:0] q1, p1, p2;

  logic [31:0]     cli_base [NCLI];
  logic [31:0]     cli_beat [NCLI];
  logic [NCLI-1:0] last_act;
  logic            use2;

  logic [NCLI-1:0] r_gnt [0:31];
  logic [NCLI-1:0] r_act [0:31];
  logic [NCLI-1:0] r_rv  [0:31];
  logic [NCLI-1:0] r_done[0:31];
  logic [NCLI-1:0] r_err [0:31];
  logic            r_en  [0:31];
  logic            r_we  [0:31];
  logic [AW-1:0]   r_ma  [0:31];
  logic [DW-1:0]   r_rd  [0:31];

  int n_chk;
  int n_err;

  elem_mem_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .DEPTH(DEPTH), .BW(BW), .RDLAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_lock_i(cfg_lock), .mode_rr_i(mode_rr),
    .req_i(req), .wr_i(wr), .addr_i(addr), .len_i(len), .wdata_i(wdata),
    .gnt_o(gnt1), .act_o(act1), .rvalid_o(rv1), .rdata_o(rd1), .done_o(done1), .err_o(err1),
    .mem_en_o(en1), .mem_we_o(we1), .mem_addr_o(ma1), .mem_din_o(md1), .mem_dout_i(dout1)
  );

  elem_mem_arbiter #(.NCLI(NCLI), .AW(AW), .DW(DW), .DEPTH(DEPTH), .BW(BW), .RDLAT(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cfg_lock_i(cfg_lock), .mode_rr_i(mode_rr),
    .req_i(req), .wr_i(wr), .addr_i(addr), .len_i(len), .wdata_i(wdata),
    .gnt_o(gnt2), .act_o(act2), .rvalid_o(rv2), .rdata_o(rd2), .done_o(done2), .err_o(err2),
    .mem_en_o(en2), .mem_we_o(we2), .mem_addr_o(ma2), .mem_din_o(md2), .mem_dout_i(dout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each client presents base + beats already accepted.
  always_comb begin
    wdata = {(NCLI*DW){1'b0}};
    for (int c = 0; c < NCLI; c++) wdata[c*DW +: DW] = cli_base[c] + cli_beat[c];
  end

  // One-cycle-latency RAM.
  always @(posedge clk) begin
    if (en1) begin
      if (we1) ram1[ma1] <= md1;
      q1 <= ram1[ma1];
    end
  end
  assign dout1 = q1;

  // Two-cycle-latency RAM.
  always @(posedge clk) begin
    if (en2) begin
      if (we2) ram2[ma2] <= md2;
      p1 <= ram2[ma2];
    end
    p2 <= p1;
  end
  assign dout2 = p2;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic setc(input int c, input logic w, input int a, input int l, input int base);
    wr[c]              = w;
    addr[c*AW +: AW]   = AW'(a);
    len[c*BW +: BW]    = BW'(l);
    cli_base[c]        = 32'(base);
    cli_beat[c]        = 32'd0;
    last_act           = {NCLI{1'b0}};
  endtask

  // Advance one clock: client data steps after an accepted beat, outputs sampled at negedge.
  task automatic rec(input int k);
    @(posedge clk);
    #1;
    for (int c = 0; c < NCLI; c++) if (last_act[c]) cli_beat[c] = cli_beat[c] + 32'd1;
    @(negedge clk);
    if (use2) begin
      r_gnt[k] = gnt2; r_act[k] = act2; r_rv[k] = rv2; r_done[k] = done2; r_err[k] = err2;
      r_en[k] = en2; r_we[k] = we2; r_ma[k] = ma2; r_rd[k] = rd2;
    end else begin
      r_gnt[k] = gnt1; r_act[k] = act1; r_rv[k] = rv1; r_done[k] = done1; r_err[k] = err1;
      r_en[k] = en1; r_we[k] = we1; r_ma[k] = ma1; r_rd[k] = rd1;
    end
    last_act = act1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) rec(31);
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; cfg_lock = 1'b0; mode_rr = 1'b0; use2 = 1'b0;
    req = {NCLI{1'b0}}; wr = {NCLI{1'b0}}; addr = {(NCLI*AW){1'b0}}; len = {(NCLI*BW){1'b0}};
    last_act = {NCLI{1'b0}};
    for (int c = 0; c < NCLI; c++) begin cli_base[c] = 32'd0; cli_beat[c] = 32'd0; end

    // Reset state
    @(negedge clk); @(negedge clk);
    check_eq("rst_gnt", {gnt2, gnt1}, 6'd0);
    check_eq("rst_act_en", {act1, en1, we1}, 5'd0);
    check_eq("rst_done_err", {done1, err1, rv1}, 9'd0);
    check_eq("rst_rdata", rd1, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Write burst from client 2 to 5..8 (preloads data for the read test)
    setc(2, 1'b1, 5, 3, 32'hA000);
    req = 3'b100; rec(0); req = 3'b000;
    for (int k = 1; k < 6; k++) rec(k);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("w5_gnt%0d", k), r_gnt[k], (k <= 3) ? 3'b100 : 3'b000);
      check_eq($sformatf("w5_we%0d", k), {r_en[k], r_we[k]}, (k <= 3) ? 2'b11 : 2'b00);
      check_eq($sformatf("w5_done%0d", k), r_done[k], (k == 4) ? 3'b100 : 3'b000);
      if (k <= 3) check_eq($sformatf("w5_addr%0d", k), r_ma[k], 7'(5 + k));
    end
    idle(2);

    // Single read, client 1, addr 5, len 3
    setc(1, 1'b0, 5, 3, 0);
    req = 3'b010; rec(0); req = 3'b000;
    for (int k = 1; k < 7; k++) rec(k);
    for (int k = 0; k < 7; k++) begin
      check_eq($sformatf("rd_gnt%0d", k), r_gnt[k], (k <= 4) ? 3'b010 : 3'b000);
      check_eq($sformatf("rd_act%0d", k), r_act[k], (k <= 3) ? 3'b010 : 3'b000);
      check_eq($sformatf("rd_rv%0d", k), r_rv[k], (k >= 1 && k <= 4) ? 3'b010 : 3'b000);
      check_eq($sformatf("rd_done%0d", k), r_done[k], (k == 5) ? 3'b010 : 3'b000);
      if (k <= 3) check_eq($sformatf("rd_addr%0d", k), {r_we[k], r_ma[k]}, {1'b0, 7'(5 + k)});
      if (k >= 1 && k <= 4) check_eq($sformatf("rd_data%0d", k), r_rd[k], 32'hA000 + 32'(k - 1));
    end
    idle(2);

    // Write wrap, client 0, addr 58, len 3, then read back
    setc(0, 1'b1, 58, 3, 32'hB000);
    req = 3'b001; rec(0); req = 3'b000;
    for (int k = 1; k < 6; k++) rec(k);
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("wrap_we%0d", k), r_we[k], (k <= 3) ? 1'b1 : 1'b0);
      check_eq($sformatf("wrap_done%0d", k), r_done[k], (k == 4) ? 3'b001 : 3'b000);
      if (k <= 3) check_eq($sformatf("wrap_addr%0d", k), r_ma[k], 7'((58 + k) % 60));
    end
    idle(2);
    setc(0, 1'b0, 58, 3, 0);
    req = 3'b001; rec(0); req = 3'b000;
    for (int k = 1; k < 7; k++) rec(k);
    for (int k = 1; k <= 4; k++) begin
      check_eq($sformatf("wrap_rv%0d", k), r_rv[k], 3'b001);
      check_eq($sformatf("wrap_rdata%0d", k), r_rd[k], 32'hB000 + 32'(k - 1));
    end
    idle(3);

    // Round-robin contention after reset, then fixed priority
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    mode_rr = 1'b1;
    setc(0, 1'b1, 10, 0, 32'h100);
    setc(1, 1'b1, 20, 0, 32'h200);
    setc(2, 1'b1, 30, 0, 32'h300);
    req = 3'b111;
    for (int k = 0; k < 8; k++) rec(k);
    req = 3'b000;
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("rr_gnt%0d", k), r_gnt[k], (k % 2 == 0) ? 3'(1 << ((k / 2) % 3)) : 3'b000);
      if (k % 2 == 0) check_eq($sformatf("rr_addr%0d", k), r_ma[k], 7'(10 * (((k / 2) % 3) + 1)));
    end
    idle(3);
    mode_rr = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 6; k++) rec(k);
    req = 3'b000;
    for (int k = 0; k < 6; k++)
      check_eq($sformatf("fix_gnt%0d", k), r_gnt[k], (k % 2 == 0) ? 3'b001 : 3'b000);
    idle(3);

    // Configuration lock
    cfg_lock = 1'b1;
    setc(1, 1'b0, 10, 0, 0);
    setc(2, 1'b0, 10, 0, 0);
    req = 3'b110;
    for (int k = 0; k < 4; k++) rec(k);
    for (int k = 0; k < 4; k++)
      check_eq($sformatf("lock_none%0d", k), {r_gnt[k], r_err[k], r_en[k]}, 7'd0);
    setc(0, 1'b1, 3, 0, 32'h55);
    req = 3'b111; rec(0); req = 3'b000;
    check_eq("lock_gnt0", r_gnt[0], 3'b001);
    idle(3);
    cfg_lock = 1'b0;
    setc(2, 1'b0, 5, 3, 0);
    req = 3'b100; rec(0); req = 3'b000; cfg_lock = 1'b1;
    for (int k = 1; k < 7; k++) rec(k);
    for (int k = 0; k < 7; k++) begin
      check_eq($sformatf("lockmid_gnt%0d", k), r_gnt[k], (k <= 4) ? 3'b100 : 3'b000);
      check_eq($sformatf("lockmid_done%0d", k), r_done[k], (k == 5) ? 3'b100 : 3'b000);
    end
    cfg_lock = 1'b0;
    idle(3);

    // Out-of-range address: err every other cycle, no memory access
    setc(1, 1'b0, 60, 0, 0);
    req = 3'b010;
    for (int k = 0; k < 4; k++) rec(k);
    req = 3'b000;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("oor_err%0d", k), r_err[k], (k % 2 == 0) ? 3'b010 : 3'b000);
      check_eq($sformatf("oor_quiet%0d", k), {r_gnt[k], r_en[k]}, 4'd0);
    end
    idle(3);

    // Asynchronous reset at beat 2 of a client-0 burst
    mode_rr = 1'b1;
    setc(0, 1'b1, 20, 5, 32'hD000);
    req = 3'b001; rec(0); req = 3'b000;
    rec(1); rec(2);
    check_eq("arst_beat2", {r_act[2], r_ma[2]}, {3'b001, 7'd22});
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out", {gnt1, act1, done1, err1, en1, we1}, 14'd0);
    check_eq("arst_addr", ma1, 7'd0);
    @(negedge clk);
    check_eq("arst_nodone", {done1, gnt1}, 6'd0);
    rst_n = 1'b1;
    setc(0, 1'b1, 1, 0, 32'h11);
    setc(1, 1'b1, 2, 0, 32'h22);
    setc(2, 1'b1, 3, 0, 32'h33);
    req = 3'b111; rec(0); req = 3'b000;
    check_eq("arst_first", r_gnt[0], 3'b001);
    rec(1);
    check_eq("arst_nodone2", r_done[1], 3'b001);
    mode_rr = 1'b0;
    idle(4);

    // Read latency 2: preload 40..47, then an 8-beat read
    setc(1, 1'b1, 40, 7, 32'hC000);
    req = 3'b010; rec(0); req = 3'b000;
    for (int k = 1; k < 10; k++) rec(k);
    check_eq("l2_wdone", r_done[8], 3'b010);
    idle(2);
    setc(1, 1'b0, 40, 7, 0);
    use2 = 1'b1;
    req = 3'b010; rec(0); req = 3'b000;
    for (int k = 1; k < 12; k++) rec(k);
    use2 = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check_eq($sformatf("l2_act%0d", k), r_act[k], (k <= 7) ? 3'b010 : 3'b000);
      check_eq($sformatf("l2_gnt%0d", k), r_gnt[k], (k <= 9) ? 3'b010 : 3'b000);
      check_eq($sformatf("l2_rv%0d", k), r_rv[k], (k >= 2 && k <= 9) ? 3'b010 : 3'b000);
      check_eq($sformatf("l2_done%0d", k), r_done[k], (k == 10) ? 3'b010 : 3'b000);
      if (k <= 7) check_eq($sformatf("l2_addr%0d", k), r_ma[k], 7'(40 + k));
      if (k >= 2 && k <= 9) check_eq($sformatf("l2_data%0d", k), r_rd[k], 32'hC000 + 32'(k - 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/elem_mem_arbiter.md
Name: elem_mem_arbiter

Overview:
- Parametrised successor to the hard-wired element-memory port mux in the top level.
- Arbitrates NCLI clients (index 0 = configuration stage, 1 = user interface, 2 = execution cores, further indices spare) onto the single-port element block RAM.
- Adds per-client request/grant handshakes, multi-beat bursts with address auto-increment and wrap, selectable fixed or round-robin priority, a configuration lock, and read-data return tagging.
- Sits between the stages and the element memory instance.

Parameters:
- NCLI, 3: number of clients (2..8).
- AW, 7: memory address width.
- DW, 800: memory word width.
- DEPTH, 60: valid locations, 0..DEPTH-1; must not exceed 2**AW.
- BW, 6: burst length field width; beats = len+1, so 1..2**BW.
- RDLAT, 1: block RAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  single clock for arbiter and memory port.
- rst  in  1  asynchronous, active-low reset.
- cfg_lock  in  1  high = only client 0 may be granted.
- mode_rr  in  1  0 = fixed priority (lowest index wins); 1 = round-robin. Sampled only in IDLE.
- req  in  NCLI  per-client request level.
- wr  in  NCLI  per-client 1 = write burst.
- addr  in  NCLI*AW  per-client start address.
- len  in  NCLI*BW  per-client beats-1.
- wdata  in  NCLI*DW  per-client write word for the current beat.
- gnt  out  NCLI  one-hot; high for the whole burst of the owner.
- act  out  NCLI  high in each cycle a beat issues for that client; client advances wdata on act.
- rvalid  out  NCLI  read data valid for that client.
- rdata  out  DW  shared read data.
- done  out  NCLI  one-cycle pulse when the burst fully completes.
- err  out  NCLI  one-cycle pulse on request rejection.
- mem_en, mem_we  out  1 each  RAM enable and write enable.
- mem_addr  out  AW  RAM address.
- mem_din  out  DW  RAM write data.
- mem_dout  in  DW  RAM read data.

Behaviour:
- Reset (rst low, async): all outputs 0, FSM to IDLE, RR pointer = NCLI-1 (so client 0 has first priority). Any in-flight burst is abandoned without done.

FSM states: IDLE, BURST, DRAIN.

IDLE:
- Eligible set = req, masked to bit 0 only when cfg_lock=1.
- Winner: fixed mode = lowest eligible index; RR mode = first eligible index after the pointer, wrapping.
- If the winner's addr >= DEPTH: pulse err[winner] for 1 cycle, no grant, stay in IDLE. A client holding req re-arbitrates every other cycle.
- Otherwise latch idx, addr, beat count, and wr. Assert gnt[idx] next cycle, go to BURST, update the RR pointer to idx.
- No eligible request: stay in IDLE.

BURST:
- One beat per cycle: mem_en=1, mem_we=wr_lat, mem_addr=cur, mem_din=wdata[idx], act[idx]=1.
- cur increments, wrapping from DEPTH-1 to 0 (not 2**AW).
- After the last beat: writes pulse done[idx], drop gnt, and go to IDLE the same edge; reads go to DRAIN.

DRAIN:
- Hold gnt, no new beats; wait for all outstanding read data, then pulse done[idx] and return to IDLE.

Read return:
- A valid/idx pipe of depth RDLAT tracks issued read beats.
- rvalid[idx] is asserted exactly RDLAT cycles after the matching act, with rdata = mem_dout.
- Order is preserved; beat k returns on cycle issue_k + RDLAT.

Handshake and ordering rules:
- req may drop mid-burst; the burst still completes, and the client ignores act.
- cfg_lock rising mid-burst does not abort the current owner; the lock applies from the next IDLE decision.
- Minimum gap between bursts is 1 IDLE cycle, so throughput is beats/(beats+1) for back-to-back requests.
- gnt, act, done, err are one-hot or zero at all times.

Decomposition:
- Package elem_mem_pkg holds:
  - state enum {IDLE, BURST, DRAIN};
  - client index constants CLI_CFG=0, CLI_UI=1, CLI_EJEC=2;
  - default DEPTH=60 and DW=800.
- Sub-module rr_pick: combinational masked round-robin/fixed priority encoder (inputs: eligible vector, pointer, mode; outputs: winner index and any).

Test Plan:
- Single read, client 1, addr=5, len=3, RDLAT=1 -> gnt[1] for 5 cycles; mem_addr 5,6,7,8; rvalid[1] on 4 consecutive cycles, each 1 cycle after act; done[1] once.
- Write wrap, client 0, addr=58, len=3 -> mem_we=1 with mem_addr 58,59,0,1; done[0] in the cycle after the last beat; RAM contents read back equal.
- RR contention: req=3'b111 held, mode_rr=1, len=0 -> grant order 0,1,2,0,...; with mode_rr=0 -> always 0.
- cfg_lock=1 with req=3'b110 -> no gnt, no err. Then req[0]=1 -> gnt[0]. Raise cfg_lock during a client-2 burst -> the burst finishes and done[2] pulses.
- addr=60 request -> err pulse only, no mem_en; rst low mid-burst at beat 2 -> all outputs 0 asynchronously, no done; after release, client 0 wins first.
- RDLAT=2, read len=7 -> 8 rvalid beats starting 2 cycles after the first act; DRAIN lasts 2 cycles before done.
